// File: rtl/spi_dac_rx.sv
// spi_dac_rx: receiver for the DAC end of an MCP4911-style SPI link.
//
// Samples the transmitter's chip select, SPI clock, data and LDAC lines in
// the sysclk domain. It decodes each 16-bit frame into BUF, GA_N, SHDN_N and
// a 10-bit code, and presents the latched DAC state as registers.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth on each SPI input (>= 2)
//
// Ports:
//   sysclk       in   system clock (50 MHz)
//   rst_n        in   asynchronous active-low reset
//   dac_cs       in   chip select, active low, asynchronous
//   dac_sck      in   SPI clock, data sampled on rising edge
//   dac_sdi      in   serial data, MSB first
//   dac_ld       in   LDAC, active low (used only with SPI_DAC_RX_LDAC_EN)
//   dac_value    out  latched 10-bit DAC code
//   dac_buf      out  latched BUF bit
//   dac_gain_n   out  latched GA_N bit
//   dac_shdn_n   out  latched SHDN_N bit
//   frame_valid  out  one-cycle pulse when the output register updates
//   frame_err    out  one-cycle pulse on a malformed frame
//   frame_cnt    out  count of output-register updates, wraps 255 -> 0
//
// Configuration macro:
//   SPI_DAC_RX_LDAC_EN  when defined, accepted frames wait in an input
//                       register until a falling edge on dac_ld. When
//                       undefined, dac_ld is ignored and an accepted frame
//                       updates the outputs directly at cs rise.

module spi_dac_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       dac_cs,
    input  logic       dac_sck,
    input  logic       dac_sdi,
    input  logic       dac_ld,
    output logic [9:0] dac_value,
    output logic       dac_buf,
    output logic       dac_gain_n,
    output logic       dac_shdn_n,
    output logic       frame_valid,
    output logic       frame_err,
    output logic [7:0] frame_cnt
);

    typedef enum logic {
        StIdle,
        StShift
    } state_t;

    // Synchronisers, reset to the idle levels of each line
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   cs_prev;
    logic                   sck_prev;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync  <= '1;
            sck_sync <= '0;
            sdi_sync <= '0;
            cs_prev  <= 1'b1;
            sck_prev <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], dac_cs};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], dac_sck};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], dac_sdi};
            cs_prev  <= cs_sync[SYNC_STAGES-1];
            sck_prev <= sck_sync[SYNC_STAGES-1];
        end
    end

    logic cs_s;
    logic sdi_s;
    logic cs_rise;
    logic sck_rise;

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync[SYNC_STAGES-1];
    assign cs_rise  = cs_s & ~cs_prev;
    assign sck_rise = sck_sync[SYNC_STAGES-1] & ~sck_prev;

    state_t      state;
    logic [15:0] shreg;
    logic [4:0]  bit_cnt;

    // Frame evaluation at cs rise
    logic frame_done;
    logic accept;
    logic bad;

    assign frame_done = (state == StShift) && cs_rise;
    assign accept     = frame_done && (bit_cnt == 5'd16) && !shreg[15];
    assign bad        = frame_done && (bit_cnt != 5'd16) && (bit_cnt != 5'd0);

    logic       do_update;
    logic [9:0] upd_value;
    logic       upd_buf;
    logic       upd_gain_n;
    logic       upd_shdn_n;

`ifdef SPI_DAC_RX_LDAC_EN
    logic [SYNC_STAGES-1:0] ld_sync;
    logic                   ld_prev;
    logic                   ld_fall;
    logic [9:0]             in_value;
    logic                   in_buf;
    logic                   in_gain_n;
    logic                   in_shdn_n;
    logic                   pend;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            ld_sync <= '1;
            ld_prev <= 1'b1;
        end else begin
            ld_sync <= {ld_sync[SYNC_STAGES-2:0], dac_ld};
            ld_prev <= ld_sync[SYNC_STAGES-1];
        end
    end

    assign ld_fall = ~ld_sync[SYNC_STAGES-1] & ld_prev;

    // An ld fall coinciding with a malformed frame is dropped so that
    // frame_valid and frame_err never pulse together; pend stays set.
    assign do_update = ld_fall && cs_s && !bad && (pend || accept);

    // A frame accepted in the same cycle as the ld fall is the newest data
    assign upd_value  = accept ? shreg[11:2] : in_value;
    assign upd_buf    = accept ? shreg[14]   : in_buf;
    assign upd_gain_n = accept ? shreg[13]   : in_gain_n;
    assign upd_shdn_n = accept ? shreg[12]   : in_shdn_n;
`else
    logic unused_ld;
    assign unused_ld = dac_ld;

    assign do_update  = accept;
    assign upd_value  = shreg[11:2];
    assign upd_buf    = shreg[14];
    assign upd_gain_n = shreg[13];
    assign upd_shdn_n = shreg[12];
`endif

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            shreg       <= '0;
            bit_cnt     <= '0;
            dac_value   <= '0;
            dac_buf     <= 1'b0;
            dac_gain_n  <= 1'b1;
            dac_shdn_n  <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= '0;
`ifdef SPI_DAC_RX_LDAC_EN
            in_value    <= '0;
            in_buf      <= 1'b0;
            in_gain_n   <= 1'b1;
            in_shdn_n   <= 1'b0;
            pend        <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= bad;

            case (state)
                StIdle: begin
                    shreg   <= '0;
                    bit_cnt <= '0;
                    if (!cs_s) begin
                        state <= StShift;
                    end
                end
                StShift: begin
                    if (cs_rise) begin
                        state <= StIdle;
                    end else if (sck_rise) begin
                        shreg <= {shreg[14:0], sdi_s};
                        if (bit_cnt != 5'd17) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
            endcase

            if (do_update) begin
                dac_value   <= upd_value;
                dac_buf     <= upd_buf;
                dac_gain_n  <= upd_gain_n;
                dac_shdn_n  <= upd_shdn_n;
                frame_valid <= 1'b1;
                frame_cnt   <= frame_cnt + 8'd1;
            end

`ifdef SPI_DAC_RX_LDAC_EN
            // Last accepted frame wins; an update consumes it
            if (accept) begin
                in_value  <= shreg[11:2];
                in_buf    <= shreg[14];
                in_gain_n <= shreg[13];
                in_shdn_n <= shreg[12];
            end
            if (do_update) begin
                pend <= 1'b0;
            end else if (accept) begin
                pend <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_spi_dac_rx.sv
`timescale 1ns/1ps
module tb_spi_dac_rx;

    localparam int S = 2;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic       dac_cs;
    logic       dac_sck;
    logic       dac_sdi;
    logic       dac_ld;
    logic [9:0] dac_value;
    logic       dac_buf;
    logic       dac_gain_n;
    logic       dac_shdn_n;
    logic       frame_valid;
    logic       frame_err;
    logic [7:0] frame_cnt;

    spi_dac_rx #(.SYNC_STAGES(S)) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .dac_cs     (dac_cs),
        .dac_sck    (dac_sck),
        .dac_sdi    (dac_sdi),
        .dac_ld     (dac_ld),
        .dac_value  (dac_value),
        .dac_buf    (dac_buf),
        .dac_gain_n (dac_gain_n),
        .dac_shdn_n (dac_shdn_n),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    always #10 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: expected DAC state plus a schedule of output events
    typedef struct {
        int       due;
        bit       upd;
        bit [9:0] val;
        bit       b;
        bit       g;
        bit       s;
    } ev_t;
    ev_t evq[$];

    bit [9:0] m_val;
    bit       m_buf, m_gain, m_shdn;
    int       m_cnt;
    bit [9:0] in_val;
    bit       in_buf, in_gain, in_shdn, pend;
    int       fv_seen = 0;
    int       fe_seen = 0;

    task automatic model_reset();
        m_val = 0; m_buf = 0; m_gain = 1; m_shdn = 0; m_cnt = 0;
        in_val = 0; in_buf = 0; in_gain = 1; in_shdn = 0; pend = 0;
        evq.delete();
    endtask

    task automatic push_upd(input bit [9:0] v, input bit b, input bit g, input bit s);
        ev_t e;
        e.due = cyc + S + 1; e.upd = 1; e.val = v; e.b = b; e.g = g; e.s = s;
        evq.push_back(e);
    endtask

    task automatic push_err();
        ev_t e;
        e.due = cyc + S + 1; e.upd = 0; e.val = 0; e.b = 0; e.g = 0; e.s = 0;
        evq.push_back(e);
    endtask

    // Apply the frame rules to the bits that were sent
    task automatic model_frame_end(input logic [31:0] word, input int n, input bit ld_sim);
        if (n == 0) return;
        if (n != 16) begin
            push_err();
            return;
        end
        if (word[15]) return;
`ifdef SPI_DAC_RX_LDAC_EN
        in_val = word[11:2]; in_buf = word[14]; in_gain = word[13]; in_shdn = word[12];
        pend = 1;
        if (ld_sim) begin
            push_upd(in_val, in_buf, in_gain, in_shdn);
            pend = 0;
        end
`else
        push_upd(word[11:2], word[14], word[13], word[12]);
`endif
    endtask

    always @(negedge sysclk) begin
        bit  efv;
        bit  efe;
        ev_t e;
        efv = 0;
        efe = 0;
        while (evq.size() > 0 && evq[0].due <= cyc) begin
            e = evq.pop_front();
            if (e.upd) begin
                efv = 1;
                m_val = e.val; m_buf = e.b; m_gain = e.g; m_shdn = e.s;
                m_cnt = (m_cnt + 1) % 256;
            end else begin
                efe = 1;
            end
        end
        chk("frame_valid", 32'(frame_valid), 32'(efv));
        chk("frame_err", 32'(frame_err), 32'(efe));
        chk("dac_value", 32'(dac_value), 32'(m_val));
        chk("dac_buf", 32'(dac_buf), 32'(m_buf));
        chk("dac_gain_n", 32'(dac_gain_n), 32'(m_gain));
        chk("dac_shdn_n", 32'(dac_shdn_n), 32'(m_shdn));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        if (frame_valid) fv_seen++;
        if (frame_err) fe_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic send_bit(input bit b);
        dac_sdi = b;
        tick(4);
        dac_sck = 1;
        tick(4);
        dac_sck = 0;
    endtask

    // Sends word[n-1:0] MSB first; ld_sim drops LDAC together with cs rise
    task automatic send_frame(input logic [31:0] word, input int n, input bit ld_sim);
        dac_cs = 0;
        tick(4);
        for (int i = n - 1; i >= 0; i--) send_bit(word[i]);
        tick(4);
        dac_cs = 1;
        if (ld_sim) dac_ld = 0;
        model_frame_end(word, n, ld_sim);
        tick(4);
        if (ld_sim) begin
            dac_ld = 1;
            tick(4);
        end
    endtask

    task automatic ld_pulse();
        dac_ld = 0;
`ifdef SPI_DAC_RX_LDAC_EN
        if (pend) begin
            push_upd(in_val, in_buf, in_gain, in_shdn);
            pend = 0;
        end
`endif
        tick(4);
        dac_ld = 1;
        tick(4);
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        dac_cs = 1; dac_sck = 0; dac_sdi = 0; dac_ld = 1;
        tick(3);
        rst_n = 1;
        tick(2);
    endtask

    int fv0, fe0;

    initial begin
        model_reset();
        rst_n = 0;
        dac_cs = 1; dac_sck = 0; dac_sdi = 0; dac_ld = 1;
        tick(3);
        chk("rst_value", 32'(dac_value), 32'h0);
        chk("rst_gain_n", 32'(dac_gain_n), 32'h1);
        chk("rst_shdn_n", 32'(dac_shdn_n), 32'h0);
        rst_n = 1;
        tick(2);

        // Ignore command: bit 15 set, data 3FF
        fv0 = fv_seen; fe0 = fe_seen;
        send_frame(32'({4'b1111, 10'h3FF, 2'b00}), 16, 0);
        ld_pulse();
        chk("ign_fv", 32'(fv_seen - fv0), 32'd0);
        chk("ign_fe", 32'(fe_seen - fe0), 32'd0);
        chk("ign_value", 32'(dac_value), 32'h0);

        // Command 0111, data 2AB, then ld pulse
        fv0 = fv_seen;
        send_frame(32'({4'b0111, 10'h2AB, 2'b00}), 16, 0);
        ld_pulse();
        chk("t1_value", 32'(dac_value), 32'h2AB);
        chk("t1_buf", 32'(dac_buf), 32'h1);
        chk("t1_gain_n", 32'(dac_gain_n), 32'h1);
        chk("t1_shdn_n", 32'(dac_shdn_n), 32'h1);
        chk("t1_fv", 32'(fv_seen - fv0), 32'd1);
        chk("t1_cnt", 32'(frame_cnt), 32'd1);

        // Short (15) and long (17) frames
        fv0 = fv_seen; fe0 = fe_seen;
        send_frame(32'h0000_1234, 15, 0);
        send_frame(32'h0001_0ABC, 17, 0);
        ld_pulse();
        chk("len_fe", 32'(fe_seen - fe0), 32'd2);
        chk("len_fv", 32'(fv_seen - fv0), 32'd0);
        chk("len_value", 32'(dac_value), 32'h2AB);
        chk("len_cnt", 32'(frame_cnt), 32'd1);

        // Reset after 8 bits, then a clean frame
        dac_cs = 0;
        tick(4);
        for (int i = 0; i < 8; i++) send_bit(i[0]);
        rst_n = 0;
        model_reset();
        dac_cs = 1; dac_sck = 0; dac_ld = 1;
        tick(1);
        chk("mid_rst_value", 32'(dac_value), 32'h0);
        chk("mid_rst_shdn_n", 32'(dac_shdn_n), 32'h0);
        chk("mid_rst_cnt", 32'(frame_cnt), 32'd0);
        tick(2);
        rst_n = 1;
        tick(2);
        send_frame(32'({4'b0111, 10'h155, 2'b00}), 16, 0);
        ld_pulse();
        chk("post_rst_value", 32'(dac_value), 32'h155);

        // Two frames before one ld pulse
        fv0 = fv_seen;
        send_frame(32'({4'b0011, 10'h001, 2'b00}), 16, 0);
        send_frame(32'({4'b0011, 10'h002, 2'b00}), 16, 0);
        ld_pulse();
`ifdef SPI_DAC_RX_LDAC_EN
        chk("two_fv", 32'(fv_seen - fv0), 32'd1);
`else
        chk("two_fv", 32'(fv_seen - fv0), 32'd2);
`endif
        chk("two_value", 32'(dac_value), 32'h002);

        // 256 frames in transmitter format, counter wraps
        do_reset();
        fv0 = fv_seen;
        for (int i = 0; i < 256; i++) begin
            logic [9:0] code;
            code = 10'(i * 3 + 1);
            send_frame(32'({4'b0011, code, 2'b00}), 16, 1);
        end
        chk("wrap_fv", 32'(fv_seen - fv0), 32'd256);
        chk("wrap_cnt", 32'(frame_cnt), 32'd0);
        chk("wrap_value", 32'(dac_value), 32'h2FE);

        tick(10);
        chk("events_drained", 32'(evq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
